wdt_timer: RTL and testbench
============================

Name: wdt_timer

Overview:
- Watchdog timer peripheral that produces the level-sensitive watchdog-timeout interrupt consumed by the CPU CSR file as WTO_interrupt; that interrupt becomes mip.MTIP.
- Software configures and kicks the watchdog through a simple valid/ready register port driven by the bus bridge.
- Once enabled, the counter advances until it reaches the programmed threshold. The interrupt is then held until software kicks the watchdog or disables it.

Parameters:
- CNT_W, 32, width of counter, threshold and data path.
- RST_WTOCNT, 32'hFFFF_FFFF, reset value of the WTOCNT threshold register.
- PRESCALE_LOG2, 4, log2 of the count-enable divider; used only when WDT_PRESCALE_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  register access request
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  2  word index: 0 WDEN, 1 WDLIVE, 2 WTOCNT, 3 WDCNT (read-only)
- req_wdata  in  CNT_W  write data
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  CNT_W  read data; 0 for write responses
- wto_interrupt  out  1  timeout interrupt level, routed to CSR WTO_interrupt
- wdt_state  out  2  current FSM state, for debug

Behaviour:
- Reset values: state IDLE, wden=0, wtocnt=RST_WTOCNT, cnt=0, wto_interrupt=0, resp_valid=0, resp_rdata=0, req_ready=1.
- Handshake:
  - A request is accepted on a clock edge where req_valid && req_ready.
  - resp_valid pulses high for exactly 1 cycle on the following edge.
  - req_ready drops while resp_valid=1, so at most one access is in flight. Back-to-back accesses therefore take 2 cycles each.
- Reads: resp_rdata holds the register value sampled at acceptance.
  - WDEN reads {0, wden}.
  - WDLIVE reads 0.
  - WTOCNT reads wtocnt.
  - WDCNT reads cnt.
- Writes, applied at the accept edge:
  - WDEN: wden <= wdata[0].
  - WDLIVE: a kick if wdata[0]=1; ignored otherwise.
  - WTOCNT: wtocnt <= wdata.
  - WDCNT: write ignored, but a response is still returned.
- FSM:
  - IDLE: cnt=0, wto=0. Moves to COUNT on the edge where WDEN is written with 1, and cnt starts at 0.
  - COUNT: cnt <= cnt+1 per count-enable. Moves to TIMEOUT on the next edge when cnt >= wtocnt (unsigned compare, evaluated before the increment). A kick sets cnt <= 0 and the state stays in COUNT.
  - TIMEOUT: wto_interrupt=1 (registered, asserted in the same cycle the state becomes TIMEOUT). cnt holds. A kick sets cnt <= 0, moves to COUNT and drops wto on that edge.
  - Any state: a write of WDEN=0 moves to IDLE, clears cnt and wto on that edge, and has priority over everything else.
- Latency: with WTOCNT=N written before enabling, wto_interrupt rises N+1 edges after the WDEN=1 accept edge. N=0 gives 1 edge.
- Kick and threshold match on the same edge: the kick wins, so cnt=0, state COUNT, no interrupt.
- Lowering wtocnt below the current cnt while in COUNT gives a timeout on the next edge, because of the >= compare.
- Counter never wraps: it stops at the threshold in TIMEOUT. If wtocnt = 2^CNT_W-1, cnt saturates there and times out on the next edge.
- Writing WDEN=1 while already in COUNT or TIMEOUT has no effect: it does not clear cnt.
- The interrupt is level-held. The CPU taking the trap does not clear it; only a kick, WDEN=0 or rst does.
- rst mid-count returns immediately to the reset values. Any in-flight response is dropped.

Optional Feature:
- Macro: WDT_PRESCALE_EN.
- Defined: an internal PRESCALE_LOG2-bit divider generates the count-enable once every 2^PRESCALE_LOG2 cycles. The divider is cleared with cnt on entry to COUNT, on a kick and on WDEN=0. Timeout latency becomes (N+1)*2^PRESCALE_LOG2 edges.
- Undefined: the count-enable is 1 every cycle, there is no divider logic, and PRESCALE_LOG2 is ignored.

Test Plan:
- Reset, then read all 4 regs -> resp_valid exactly 1 cycle after each accept; rdata = 0, 0, 32'hFFFF_FFFF, 0. wto_interrupt=0 throughout.
- Write WTOCNT=5 then WDEN=1 (prescale off) -> wto_interrupt rises exactly 6 edges after the WDEN accept; WDCNT read returns 5; wdt_state=TIMEOUT.
- In TIMEOUT, write WDLIVE=1 -> wto drops on the accept edge, cnt=0, state COUNT; re-times out 6 edges later.
- WTOCNT=10, kick issued on the edge where cnt=10 -> no interrupt pulse; cnt=0 after that edge. Separately, with cnt=8, write WTOCNT=3 -> timeout on the next edge.
- During COUNT with cnt=4, write WDEN=0 -> IDLE, cnt=0, wto=0. Assert rst mid-TIMEOUT -> wto drops immediately (asynchronous) and wtocnt returns to 32'hFFFF_FFFF.
- WDT_PRESCALE_EN defined, PRESCALE_LOG2=2, WTOCNT=3 -> wto rises 16 edges after enable. Back-to-back requests observe req_ready=0 during resp_valid.

Source files
------------

// File: rtl/wdt_timer_if.sv
// wdt_timer_if: register-port bundle between the bus bridge and the
// watchdog timer.
//   req_valid  - request strobe from the bridge
//   req_ready  - watchdog can accept a request this cycle
//   req_write  - 1 = write, 0 = read
//   req_addr   - word index: 0 WDEN, 1 WDLIVE, 2 WTOCNT, 3 WDCNT
//   req_wdata  - write data
//   resp_valid - one-cycle response strobe
//   resp_rdata - read data, zero for write responses
// The bridge uses the master modport; the watchdog uses the slave modport.
interface wdt_timer_if #(
   parameter int CNT_W = 32
);
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [1:0]       req_addr;
   logic [CNT_W-1:0] req_wdata;
   logic             resp_valid;
   logic [CNT_W-1:0] resp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/wdt_timer.sv
// wdt_timer: watchdog timer peripheral. Once enabled, the counter advances
// until it reaches the WTOCNT threshold. The watchdog then raises
// wto_interrupt, which feeds the CSR WTO_interrupt input (mip.MTIP). The
// interrupt stays high until software kicks the watchdog through WDLIVE or
// disables it through WDEN.
// Ports:
//   clk           - clock
//   rst           - asynchronous, active-high reset
//   bus           - wdt_timer_if.slave register port (valid/ready request,
//                   one-cycle response strobe)
//   wto_interrupt - level timeout interrupt
//   wdt_state     - current FSM state, for debug (0 IDLE, 1 COUNT, 2 TIMEOUT)
// Optional build macro WDT_PRESCALE_EN: when defined, the counter advances
// once every 2**PRESCALE_LOG2 cycles instead of every cycle.
module wdt_timer #(
   parameter int               CNT_W         = 32,
   parameter logic [CNT_W-1:0] RST_WTOCNT    = 32'hFFFF_FFFF,
   parameter int               PRESCALE_LOG2 = 4
) (
   input  logic             clk,
   input  logic             rst,
   wdt_timer_if.slave       bus,
   output logic             wto_interrupt,
   output logic [1:0]       wdt_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      TIMEOUT = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_WDEN   = 2'd0;
   localparam logic [1:0] ADDR_WDLIVE = 2'd1;
   localparam logic [1:0] ADDR_WTOCNT = 2'd2;
   localparam logic [1:0] ADDR_WDCNT  = 2'd3;

   // The divider width must be at least one bit.
   if (PRESCALE_LOG2 < 1 || PRESCALE_LOG2 > CNT_W) begin : g_bad_prescale
      $error("wdt_timer: PRESCALE_LOG2 out of range");
   end

   state_t           state;
   logic             wden;
   logic [CNT_W-1:0] wtocnt;
   logic [CNT_W-1:0] cnt;
   logic             resp_valid_q;
   logic [CNT_W-1:0] resp_rdata_q;
   logic             wto_q;

   logic             accept;
   logic             wr_wden;
   logic             wden_on;
   logic             wden_off;
   logic             kick;
   logic             wr_wtocnt;
   logic             count_en;
   logic [CNT_W-1:0] read_data;

   // Only one access may be in flight, so the port stays busy for the
   // cycle in which the response is presented.
   assign accept    = bus.req_valid && !resp_valid_q;
   assign wr_wden   = accept && bus.req_write && (bus.req_addr == ADDR_WDEN);
   assign wden_on   = wr_wden && bus.req_wdata[0];
   assign wden_off  = wr_wden && !bus.req_wdata[0];
   assign kick      = accept && bus.req_write && (bus.req_addr == ADDR_WDLIVE)
                      && bus.req_wdata[0];
   assign wr_wtocnt = accept && bus.req_write && (bus.req_addr == ADDR_WTOCNT);

   // Register read mux; the value is captured into the response register
   // on the accept edge.
   always_comb begin
      read_data = '0;
      case (bus.req_addr)
         ADDR_WDEN:   read_data = {{(CNT_W-1){1'b0}}, wden};
         ADDR_WDLIVE: read_data = '0;
         ADDR_WTOCNT: read_data = wtocnt;
         ADDR_WDCNT:  read_data = cnt;
         default:     read_data = '0;
      endcase
   end

`ifdef WDT_PRESCALE_EN
   logic [PRESCALE_LOG2-1:0] div;

   // The divider restarts whenever the counter restarts, so every count
   // period after entering COUNT or after a kick is a full 2**PRESCALE_LOG2
   // cycles long.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
      end else if (wden_off || kick || state != COUNT) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign count_en = &div;
`else
   assign count_en = 1'b1;
`endif

   // Register port, configuration registers and watchdog FSM. Disabling
   // through WDEN overrides every other event on the same edge. A kick
   // overrides a threshold match on the same edge. The counter stops at the
   // threshold instead of wrapping, so a threshold at the maximum count
   // still times out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wden         <= 1'b0;
         wtocnt       <= RST_WTOCNT;
         cnt          <= '0;
         wto_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= accept;
         resp_rdata_q <= (accept && !bus.req_write) ? read_data : '0;

         if (wr_wden) begin
            wden <= bus.req_wdata[0];
         end
         if (wr_wtocnt) begin
            wtocnt <= bus.req_wdata;
         end

         if (wden_off) begin
            state <= IDLE;
            cnt   <= '0;
            wto_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt   <= '0;
                  wto_q <= 1'b0;
                  if (wden_on) begin
                     state <= COUNT;
                  end
               end
               COUNT: begin
                  if (kick) begin
                     cnt <= '0;
                  end else if (count_en) begin
                     if (cnt >= wtocnt) begin
                        state <= TIMEOUT;
                        wto_q <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               TIMEOUT: begin
                  if (kick) begin
                     cnt   <= '0;
                     state <= COUNT;
                     wto_q <= 1'b0;
                  end else begin
                     wto_q <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  wto_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.req_ready  = !resp_valid_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign wto_interrupt  = wto_q;
   assign wdt_state      = state;

endmodule

// File: tb/tb_wdt_timer.sv
// tb_wdt_timer: directed self-checking bench for wdt_timer. It drives the
// register port through a wdt_timer_if instance and checks the handshake,
// the register reads, the timeout latency, the kick and disable behaviour,
// the threshold-lowering case and the asynchronous reset. The prescaled
// build uses PRESCALE_LOG2 = 2, so one count step takes 4 cycles.
module tb_wdt_timer;

   localparam int CNT_W = 32;
`ifdef WDT_PRESCALE_EN
   localparam int SCALE = 4;
`else
   localparam int SCALE = 1;
`endif

   logic       clk;
   logic       rst;
   logic       wto;
   logic [1:0] state;

   int         n_asserts;
   int         n_fails;
   int         n_edges;
   logic [31:0] rdata;

   wdt_timer_if #(.CNT_W(CNT_W)) bus_if ();

   wdt_timer #(
      .CNT_W(CNT_W),
      .RST_WTOCNT(32'hFFFF_FFFF),
      .PRESCALE_LOG2(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if.slave),
      .wto_interrupt(wto),
      .wdt_state(state)
   );

   // Free-running clock; rising edges fall at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value with its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_asserts++;
      assert (observed === expected)
      else begin
         n_fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One register access. The request is raised on a falling edge and
   // waits for req_ready. The task returns 1 time unit after the accept
   // edge with the response captured in rdata.
   task automatic applyStimulus(input logic write, input logic [1:0] addr,
                                input logic [31:0] wdata,
                                output logic [31:0] rdata_out);
      int waits;
      @(negedge clk);
      bus_if.req_valid = 1'b1;
      bus_if.req_write = write;
      bus_if.req_addr  = addr;
      bus_if.req_wdata = wdata;
      waits = 0;
      while (bus_if.req_ready !== 1'b1 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      checkOutput("ready_before_accept", {31'd0, bus_if.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("resp_valid_after_accept", {31'd0, bus_if.resp_valid}, 32'd1);
      checkOutput("ready_low_during_resp", {31'd0, bus_if.req_ready}, 32'd0);
      rdata_out = bus_if.resp_rdata;
      if (write) begin
         checkOutput("write_resp_rdata_zero", rdata_out, 32'd0);
      end
      bus_if.req_valid = 1'b0;
   endtask

   // Count rising edges until wto_interrupt is seen high, with a bound.
   task automatic waitTimeout(output int edges);
      edges = 0;
      while (wto !== 1'b1 && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   initial begin
      n_asserts        = 0;
      n_fails          = 0;
      rst              = 1'b1;
      bus_if.req_valid = 1'b0;
      bus_if.req_write = 1'b0;
      bus_if.req_addr  = 2'd0;
      bus_if.req_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] reset values and register reads");
      checkOutput("reset_ready", {31'd0, bus_if.req_ready}, 32'd1);
      checkOutput("reset_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
      checkOutput("reset_wto", {31'd0, wto}, 32'd0);
      checkOutput("reset_state", {30'd0, state}, 32'd0);
      applyStimulus(1'b0, 2'd0, 32'd0, rdata);
      checkOutput("read_wden_reset", rdata, 32'd0);
      @(posedge clk); #1;
      checkOutput("resp_valid_one_cycle", {31'd0, bus_if.resp_valid}, 32'd0);
      applyStimulus(1'b0, 2'd1, 32'd0, rdata);
      checkOutput("read_wdlive_reset", rdata, 32'd0);
      applyStimulus(1'b0, 2'd2, 32'd0, rdata);
      checkOutput("read_wtocnt_reset", rdata, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 2'd3, 32'd0, rdata);
      checkOutput("read_wdcnt_reset", rdata, 32'd0);
      checkOutput("wto_low_after_reads", {31'd0, wto}, 32'd0);

      $display("[TB] timeout latency with WTOCNT=5");
      applyStimulus(1'b1, 2'd2, 32'd5, rdata);
      applyStimulus(1'b1, 2'd0, 32'd1, rdata);
      checkOutput("state_count_after_enable", {30'd0, state}, 32'd1);
      waitTimeout(n_edges);
      checkOutput("timeout_latency_5", n_edges, 6 * SCALE);
      checkOutput("state_timeout", {30'd0, state}, 32'd2);
      applyStimulus(1'b0, 2'd3, 32'd0, rdata);
      checkOutput("wdcnt_at_timeout", rdata, 32'd5);
      applyStimulus(1'b0, 2'd0, 32'd0, rdata);
      checkOutput("read_wden_enabled", rdata, 32'd1);
      checkOutput("wto_level_held", {31'd0, wto}, 32'd1);

      $display("[TB] kick in TIMEOUT");
      applyStimulus(1'b1, 2'd1, 32'd1, rdata);
      checkOutput("kick_drops_wto", {31'd0, wto}, 32'd0);
      checkOutput("kick_state_count", {30'd0, state}, 32'd1);
      waitTimeout(n_edges);
      checkOutput("retimeout_latency", n_edges, 6 * SCALE);
      checkOutput("retimeout_state", {30'd0, state}, 32'd2);

`ifndef WDT_PRESCALE_EN
      $display("[TB] kick on the threshold edge");
      applyStimulus(1'b1, 2'd2, 32'd10, rdata);
      applyStimulus(1'b1, 2'd1, 32'd1, rdata);
      repeat (10) @(posedge clk);
      applyStimulus(1'b1, 2'd1, 32'd1, rdata);
      checkOutput("kick_vs_match_wto", {31'd0, wto}, 32'd0);
      checkOutput("kick_vs_match_state", {30'd0, state}, 32'd1);
      applyStimulus(1'b0, 2'd3, 32'd0, rdata);
      checkOutput("cnt_restart_after_kick", rdata, 32'd1);

      $display("[TB] lowering WTOCNT below cnt");
      applyStimulus(1'b1, 2'd0, 32'd0, rdata);
      applyStimulus(1'b1, 2'd0, 32'd1, rdata);
      repeat (8) @(posedge clk);
      applyStimulus(1'b1, 2'd2, 32'd3, rdata);
      checkOutput("lower_thr_no_wto_yet", {31'd0, wto}, 32'd0);
      @(posedge clk); #1;
      checkOutput("lower_thr_wto", {31'd0, wto}, 32'd1);
      checkOutput("lower_thr_state", {30'd0, state}, 32'd2);
`endif

      $display("[TB] disable during COUNT");
      applyStimulus(1'b1, 2'd2, 32'd100, rdata);
      applyStimulus(1'b1, 2'd0, 32'd0, rdata);
      applyStimulus(1'b1, 2'd0, 32'd1, rdata);
      repeat (4 * SCALE) @(posedge clk);
      applyStimulus(1'b0, 2'd3, 32'd0, rdata);
      checkOutput("cnt_before_disable", rdata, 32'd4);
      applyStimulus(1'b1, 2'd0, 32'd1, rdata);
      applyStimulus(1'b0, 2'd3, 32'd0, rdata);
      checkOutput("reenable_keeps_cnt", rdata, 32'd4 + 32'(4 / SCALE));
      applyStimulus(1'b1, 2'd0, 32'd0, rdata);
      checkOutput("disable_state_idle", {30'd0, state}, 32'd0);
      checkOutput("disable_wto_low", {31'd0, wto}, 32'd0);
      applyStimulus(1'b0, 2'd3, 32'd0, rdata);
      checkOutput("disable_cnt_zero", rdata, 32'd0);
      applyStimulus(1'b0, 2'd0, 32'd0, rdata);
      checkOutput("read_wden_disabled", rdata, 32'd0);

      $display("[TB] asynchronous reset in TIMEOUT");
      applyStimulus(1'b1, 2'd2, 32'd2, rdata);
      applyStimulus(1'b1, 2'd0, 32'd1, rdata);
      waitTimeout(n_edges);
      checkOutput("timeout_latency_2", n_edges, 3 * SCALE);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("async_rst_wto", {31'd0, wto}, 32'd0);
      checkOutput("async_rst_state", {30'd0, state}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 2'd2, 32'd0, rdata);
      checkOutput("wtocnt_after_rst", rdata, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 2'd0, 32'd0, rdata);
      checkOutput("wden_after_rst", rdata, 32'd0);
      checkOutput("wto_after_rst", {31'd0, wto}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
